// File: rtl/bshift_reg_if.sv
// Serial-in / parallel-out bus for bshift_reg.
// BSHIFT_REG_FILL_CNT_EN adds the fill counter and full flag.
interface bshift_reg_if #(
   parameter int COUNT = 4
);
   localparam int CW = $clog2(COUNT + 1);

   logic             i_bit;
   logic [COUNT-1:0] o_data;
`ifdef BSHIFT_REG_FILL_CNT_EN
   logic [CW-1:0]    o_fill_cnt;
   logic             o_full;

   modport master (output i_bit, input  o_data, input  o_fill_cnt, input  o_full);
   modport slave  (input  i_bit, output o_data, output o_fill_cnt, output o_full);
`else
   modport master (output i_bit, input  o_data);
   modport slave  (input  i_bit, output o_data);
`endif
endinterface

// File: rtl/bshift_reg.sv
// Serial-in, parallel-out shift register with synchronous clear.
// Optional saturating fill counter and full flag under BSHIFT_REG_FILL_CNT_EN.
module bshift_reg #(
   parameter int COUNT = 4
) (
   input  logic         clk,
   input  logic         i_sclr,
   bshift_reg_if.slave  bus
);
   logic [COUNT-1:0] data_q;

   // Clear has priority, so i_bit (even X/Z) never reaches the flops on a clear edge.
   generate
      if (COUNT == 1) begin : g_one
         always_ff @(posedge clk) begin
            if (i_sclr) data_q <= '0;
            else        data_q <= bus.i_bit;
         end
      end else begin : g_multi
         always_ff @(posedge clk) begin
            if (i_sclr) data_q <= '0;
            else        data_q <= {data_q[COUNT-2:0], bus.i_bit};
         end
      end
   endgenerate

   assign bus.o_data = data_q;

`ifdef BSHIFT_REG_FILL_CNT_EN
   localparam int CW = $clog2(COUNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(COUNT);

   logic [CW-1:0] fill_q;
   logic [CW-1:0] fill_nxt;
   logic          full_q;

   always_comb begin
      fill_nxt = fill_q;
      if (fill_q != CNT_MAX) fill_nxt = fill_q + CW'(1);
   end

   // Full is registered off the next count so it tracks o_fill_cnt on the same edge.
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         fill_q <= '0;
         full_q <= 1'b0;
      end else begin
         fill_q <= fill_nxt;
         full_q <= (fill_nxt == CNT_MAX);
      end
   end

   assign bus.o_fill_cnt = fill_q;
   assign bus.o_full     = full_q;
`endif
endmodule

// File: tb/tb_bshift_reg.sv
// Directed bench for bshift_reg at COUNT=4, 8 and 1; fill counter checks
// compile in with BSHIFT_REG_FILL_CNT_EN.
module tb_bshift_reg;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic sclr4, sclr8, sclr1;

   bshift_reg_if #(.COUNT(4)) bus4 ();
   bshift_reg_if #(.COUNT(8)) bus8 ();
   bshift_reg_if #(.COUNT(1)) bus1 ();

   bshift_reg #(.COUNT(4)) dut4 (.clk(clk), .i_sclr(sclr4), .bus(bus4));
   bshift_reg #(.COUNT(8)) dut8 (.clk(clk), .i_sclr(sclr8), .bus(bus8));
   bshift_reg #(.COUNT(1)) dut1 (.clk(clk), .i_sclr(sclr1), .bus(bus1));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       sclr;
      logic       bit_in;
      logic [3:0] exp;
   } vec_t;

   vec_t vt[$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      sclr4 = 1'b1; sclr8 = 1'b1; sclr1 = 1'b1;
      bus4.i_bit = 1'b0; bus8.i_bit = 1'b0; bus1.i_bit = 1'b0;

      // COUNT=4 vectors: {i_sclr, i_bit, o_data after the edge}
      vt.push_back('{1'b1, 1'b0, 4'b0000});  // initial clear
      vt.push_back('{1'b0, 1'b0, 4'b0000});
      vt.push_back('{1'b0, 1'b1, 4'b0001});
      vt.push_back('{1'b0, 1'b1, 4'b0011});
      vt.push_back('{1'b0, 1'b0, 4'b0110});
      vt.push_back('{1'b0, 1'b0, 4'b1100});
      vt.push_back('{1'b0, 1'b0, 4'b1000});
      vt.push_back('{1'b0, 1'b1, 4'b0001});  // load 1111
      vt.push_back('{1'b0, 1'b1, 4'b0011});
      vt.push_back('{1'b0, 1'b1, 4'b0111});
      vt.push_back('{1'b0, 1'b1, 4'b1111});
      vt.push_back('{1'b1, 1'b1, 4'b0000});  // clear beats i_bit=1
      vt.push_back('{1'b0, 1'b1, 4'b0001});
      vt.push_back('{1'b1, 1'b0, 4'b0000});  // held clear, i_bit toggling
      vt.push_back('{1'b1, 1'b1, 4'b0000});
      vt.push_back('{1'b1, 1'b0, 4'b0000});
      vt.push_back('{1'b0, 1'b1, 4'b0001});  // resume from zero
      vt.push_back('{1'b0, 1'b0, 4'b0010});
      vt.push_back('{1'b0, 1'b1, 4'b0101});
      vt.push_back('{1'b0, 1'b1, 4'b1011});
      vt.push_back('{1'b0, 1'b0, 4'b0110});  // four zeros flush everything
      vt.push_back('{1'b0, 1'b0, 4'b1100});
      vt.push_back('{1'b0, 1'b0, 4'b1000});
      vt.push_back('{1'b0, 1'b0, 4'b0000});
      vt.push_back('{1'b0, 1'b1, 4'b0001});
      vt.push_back('{1'b1, 1'bx, 4'b0000});  // X on i_bit ignored during clear

      for (int i = 0; i < vt.size(); i++) begin
         sclr4      = vt[i].sclr;
         bus4.i_bit = vt[i].bit_in;
         tick();
         chk($sformatf("c4_vec%0d", i), 64'(bus4.o_data), 64'(vt[i].exp));
      end

      // COUNT=8: a single 1 walks to the MSB, then drops off
      sclr4 = 1'b1; bus4.i_bit = 1'b0;
      sclr8 = 1'b1; bus8.i_bit = 1'b1;
      tick();
      chk("c8_clear", 64'(bus8.o_data), 64'h00);
      sclr8 = 1'b0;
      tick();
      chk("c8_first", 64'(bus8.o_data), 64'h01);
      bus8.i_bit = 1'b0;
      for (int k = 1; k < 8; k++) tick();
      chk("c8_msb", 64'(bus8.o_data), 64'h80);
      tick();
      chk("c8_drop", 64'(bus8.o_data), 64'h00);

      // COUNT=1
      bus1.i_bit = 1'b1;
      tick();
      chk("c1_clear", 64'(bus1.o_data), 64'h0);
      sclr1 = 1'b0;
      tick();
      chk("c1_one", 64'(bus1.o_data), 64'h1);
      bus1.i_bit = 1'b0;
      tick();
      chk("c1_zero", 64'(bus1.o_data), 64'h0);
      bus1.i_bit = 1'b1;
      tick();
      chk("c1_one_again", 64'(bus1.o_data), 64'h1);

`ifdef BSHIFT_REG_FILL_CNT_EN
      begin
         logic [2:0] exp_cnt [5];
         logic       exp_full[5];
         exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
         exp_full = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
         sclr4 = 1'b1;
         tick();
         chk("fill_clr_cnt",  64'(bus4.o_fill_cnt), 64'd0);
         chk("fill_clr_full", 64'(bus4.o_full),     64'd0);
         sclr4 = 1'b0;
         for (int k = 0; k < 5; k++) begin
            bus4.i_bit = k[0];
            tick();
            chk($sformatf("fill_cnt%0d", k),  64'(bus4.o_fill_cnt), 64'(exp_cnt[k]));
            chk($sformatf("fill_full%0d", k), 64'(bus4.o_full),     64'(exp_full[k]));
         end
         sclr4 = 1'b1;
         tick();
         chk("fill_reclr_cnt",  64'(bus4.o_fill_cnt), 64'd0);
         chk("fill_reclr_full", 64'(bus4.o_full),     64'd0);
         // COUNT=1 saturates after one shift
         sclr1 = 1'b1;
         tick();
         sclr1 = 1'b0;
         tick();
         chk("fill1_cnt",  64'(bus1.o_fill_cnt), 64'd1);
         chk("fill1_full", 64'(bus1.o_full),     64'd1);
         tick();
         chk("fill1_sat",  64'(bus1.o_fill_cnt), 64'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bshift_reg.md
BSHIFT_REG -- requirements
Module: bshift_reg

Interface
REQ-001 Parameter COUNT, default 4, register width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_sclr  input  1  reset is synchronous and active-high; clears the register.
REQ-004 i_bit  input  1  serial data bit shifted in at the LSB.
REQ-005 o_data  output  COUNT  parallel register contents, driven directly from flops.
REQ-006 With BSHIFT_REG_FILL_CNT_EN defined: o_fill_cnt  output  $clog2(COUNT+1)  number of valid bits shifted in since the last clear, saturating.
REQ-007 With BSHIFT_REG_FILL_CNT_EN defined: o_full  output  1  high when o_fill_cnt equals COUNT.

Function
REQ-008 On each rising clk edge with i_sclr low, o_data SHALL become {o_data[COUNT-2:0], i_bit}; the previous MSB is discarded.
REQ-009 For COUNT=1, o_data SHALL become i_bit on each non-clear edge.
REQ-010 Latency: i_bit sampled at edge N SHALL appear at o_data[0] immediately after edge N and at o_data[k] after edge N+k, for k < COUNT.
REQ-011 The register SHALL shift every cycle; there is no enable and no hold state.
REQ-012 o_data SHALL be purely registered, with no combinational path from i_bit or i_sclr to any output.
REQ-013 When i_sclr is high at a rising edge, i_bit SHALL be ignored for that edge, including X or Z values.
REQ-014 After COUNT consecutive edges with i_bit=0, o_data SHALL be all zeros regardless of prior contents.

Reset
REQ-015 When i_sclr is high at a rising edge, o_data SHALL be all zeros after that edge.
REQ-016 i_sclr SHALL have priority over shifting; there is no asynchronous reset.
REQ-017 While i_sclr is held high across multiple edges, o_data SHALL remain all zeros.
REQ-018 Asserting i_sclr mid-stream SHALL discard all shifted bits; shifting resumes from zero on the first edge with i_sclr low.
REQ-019 Output values before the first clear edge SHALL be unspecified; users must clear before use.
REQ-020 With BSHIFT_REG_FILL_CNT_EN defined, a clear edge SHALL set o_fill_cnt to 0 and o_full to 0.

Configuration
REQ-021 The macro BSHIFT_REG_FILL_CNT_EN SHALL compile the fill counter in or out.
REQ-022 With BSHIFT_REG_FILL_CNT_EN defined:
- o_fill_cnt increments by 1 on each non-clear edge.
- o_fill_cnt saturates at COUNT.
- o_full = (o_fill_cnt == COUNT), registered.
REQ-023 Without BSHIFT_REG_FILL_CNT_EN:
- o_fill_cnt and o_full do not exist.
- No counter logic is present.
- o_data behaviour is identical to the enabled build.

Verification
REQ-024 COUNT=4: i_sclr=1 for one edge, then i_sclr=0 -> o_data=0000 after the clear edge.
REQ-025 COUNT=4, after clear: i_bit sequence 0,1,1,0,0,0 on successive edges -> o_data 0000, 0001, 0011, 0110, 1100, 1000.
REQ-026 COUNT=4: load 1111, then assert i_sclr with i_bit=1 for one edge -> o_data=0000 on that edge; the next edge with i_bit=1 and i_sclr=0 -> 0001.
REQ-027 COUNT=4: hold i_sclr=1 for 3 edges with i_bit toggling -> o_data stays 0000 throughout.
REQ-028 COUNT=8: shift in 1 then seven 0s -> o_data=10000000; one more 0 -> 00000000 (MSB dropped).
REQ-029 BSHIFT_REG_FILL_CNT_EN defined, COUNT=4: after clear, 5 shift edges -> o_fill_cnt 1,2,3,4,4 and o_full 0,0,0,1,1; a clear edge -> o_fill_cnt=0, o_full=0.
